// File: rtl/z480_pkg.sv
// rtl/z480_pkg.sv - Z480 uop types, FU lane enumeration and fu-to-lane mapping
package z480_pkg;

    localparam int Z480_NUM_FU = 5;

    typedef enum logic [2:0] {
        Z480_LANE_INT = 3'd0,
        Z480_LANE_BR  = 3'd1,
        Z480_LANE_MD  = 3'd2,
        Z480_LANE_VEC = 3'd3,
        Z480_LANE_MEM = 3'd4
    } z480_fu_lane_e;

    typedef struct packed {
        logic [2:0]  fu;
        logic [7:0]  opc;
        logic [15:0] imm;
    } z480_uop_t;

    typedef struct packed {
        z480_uop_t   uop;
        logic [5:0]  rob_idx;
    } z480_uop_issue_t;

    typedef struct packed {
        z480_uop_issue_t uop;
        logic [7:0]      tag;
    } z480_uop_tagged_t;

    // Unlisted fu encodings fall back to INT, as the legacy scheduler did.
    function automatic z480_fu_lane_e z480_fu_to_lane(input logic [2:0] fu);
        z480_fu_lane_e lane;
        case (fu)
            3'd1:    lane = Z480_LANE_BR;
            3'd2:    lane = Z480_LANE_MD;
            3'd3:    lane = Z480_LANE_VEC;
            3'd4:    lane = Z480_LANE_MEM;
            default: lane = Z480_LANE_INT;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/z480_fu_lane_fifo.sv
// rtl/z480_fu_lane_fifo.sv - per-lane uop FIFO with registered head and synchronous clear
module z480_fu_lane_fifo
    import z480_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  z480_uop_tagged_t             push_uop,
    input  logic                         pop,
    input  logic                         clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output z480_uop_tagged_t             head_uop
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    z480_uop_tagged_t r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push)
                r_wr <= ptr_inc(r_wr);
            if (w_pop)
                r_rd <= ptr_inc(r_rd);
            if (push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            r_mem[r_wr] <= push_uop;
    end

    always_comb begin
        head_uop = '0;
        if (r_count != '0)
            head_uop = r_mem[r_rd];
    end

    assign count      = r_count;
    assign head_valid = (r_count != '0);

endmodule

// File: rtl/z480_fu_dispatch.sv
// rtl/z480_fu_dispatch.sv - routes tagged uops from NUM_SRC sources to five FU lanes
// Optional stall counters built when Z480_DISPATCH_PERF_EN is defined.
module z480_fu_dispatch
    import z480_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  z480_uop_tagged_t        src_uop [NUM_SRC],
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [Z480_NUM_FU-1:0]  fu_valid,
    output z480_uop_tagged_t        fu_uop [Z480_NUM_FU],
    input  logic [Z480_NUM_FU-1:0]  fu_ready,
    output logic [31:0]             perf_stall [Z480_NUM_FU]
);
    localparam int RRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    // Returns {found, index} of the first requester at or after ptr, modulo NUM_SRC.
    function automatic logic [RRW:0] rr_grant(input logic [NUM_SRC-1:0] req,
                                              input logic [RRW-1:0]     ptr);
        logic [RRW:0] res;
        int           j;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SRC;
            if (req[j])
                res = {1'b1, RRW'(j)};
        end
        return res;
    endfunction

    z480_fu_lane_e    w_src_lane [NUM_SRC];
    logic [Z480_NUM_FU-1:0] w_grant;
    logic [Z480_NUM_FU-1:0] w_full;
    logic [Z480_NUM_FU-1:0] w_pop;
    logic [RRW-1:0]   w_gidx  [Z480_NUM_FU];
    logic [CW-1:0]    w_count [Z480_NUM_FU];
    z480_uop_tagged_t w_push_uop [Z480_NUM_FU];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            w_src_lane[i] = z480_fu_to_lane(src_uop[i].uop.uop.fu);
    end

    always_comb begin
        src_ready = '0;
        for (int l = 0; l < Z480_NUM_FU; l++)
            for (int i = 0; i < NUM_SRC; i++)
                if (w_grant[l] && (w_gidx[l] == RRW'(i)))
                    src_ready[i] = 1'b1;
    end

    for (genvar g = 0; g < Z480_NUM_FU; g++) begin : g_lane
        logic [NUM_SRC-1:0] w_req;
        logic [RRW:0]       w_pick;
        logic [RRW-1:0]     r_rr_ptr;

        always_comb begin
            for (int i = 0; i < NUM_SRC; i++)
                w_req[i] = src_valid[i] && (w_src_lane[i] == z480_fu_lane_e'(g));
        end

        assign w_pick        = rr_grant(w_req, r_rr_ptr);
        assign w_full[g]     = (w_count[g] == CW'(OUT_DEPTH));
        assign w_grant[g]    = !flush && !w_full[g] && w_pick[RRW];
        assign w_gidx[g]     = w_pick[RRW-1:0];
        assign w_push_uop[g] = src_uop[w_gidx[g]];
        assign w_pop[g]      = fu_valid[g] && fu_ready[g];

        // rr_ptr survives flush so fairness is not reset by mispredicts.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_rr_ptr <= '0;
            else if (w_grant[g])
                r_rr_ptr <= (w_gidx[g] == RRW'(NUM_SRC - 1)) ? '0 : w_gidx[g] + 1'b1;
        end

        z480_fu_lane_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (w_grant[g]),
            .push_uop   (w_push_uop[g]),
            .pop        (w_pop[g]),
            .clr        (flush),
            .count      (w_count[g]),
            .head_valid (fu_valid[g]),
            .head_uop   (fu_uop[g])
        );

`ifdef Z480_DISPATCH_PERF_EN
        logic [31:0] r_perf;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_perf <= '0;
            else if ((|w_req) && !flush && w_full[g] && (r_perf != 32'hFFFF_FFFF))
                r_perf <= r_perf + 32'd1;
        end
        assign perf_stall[g] = r_perf;
`else
        assign perf_stall[g] = '0;
`endif
    end

endmodule

// File: tb/tb_z480_fu_dispatch.sv
// tb/tb_z480_fu_dispatch.sv - directed and randomized bench with queue-based lane model
module tb_z480_fu_dispatch;
    import z480_pkg::*;

    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int NF    = Z480_NUM_FU;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [NS-1:0]        src_valid;
    z480_uop_tagged_t     src_uop [NS];
    logic [NS-1:0]        src_ready;
    logic [NF-1:0]        fu_valid;
    z480_uop_tagged_t     fu_uop [NF];
    logic [NF-1:0]        fu_ready;
    logic [31:0]          perf_stall [NF];

    z480_fu_dispatch #(.NUM_SRC(NS), .OUT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_uop    (src_uop),
        .src_ready  (src_ready),
        .fu_valid   (fu_valid),
        .fu_uop     (fu_uop),
        .fu_ready   (fu_ready),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per lane, a round-robin start index per lane.
    z480_uop_tagged_t mq [NF][$];
    int               mrr [NF];
    longint           mperf [NF];
    logic [NS-1:0]    last_ready;

    function automatic int lane_of(input logic [2:0] fu);
        return (fu <= 3'd4) ? int'(fu) : 0;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NF; l++) begin
            mq[l].delete();
            mrr[l]   = 0;
            mperf[l] = 0;
        end
    endtask

    task automatic offer(input int i, input logic v, input logic [2:0] fu, input logic [7:0] tag);
        z480_uop_tagged_t u;
        u.uop.uop.fu   = fu;
        u.uop.uop.opc  = 8'($urandom);
        u.uop.uop.imm  = 16'($urandom);
        u.uop.rob_idx  = 6'($urandom);
        u.tag          = tag;
        src_valid[i]   = v;
        src_uop[i]     = u;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int               grant [NF];
        bit               hasreq [NF];
        logic [NS-1:0]    exp_ready;
        z480_uop_tagged_t exp_head;
        int               s;
        #1;
        exp_ready = '0;
        for (int l = 0; l < NF; l++) begin
            grant[l]  = -1;
            hasreq[l] = 0;
            for (int k = 0; k < NS; k++) begin
                s = (mrr[l] + k) % NS;
                if (src_valid[s] && lane_of(src_uop[s].uop.uop.fu) == l) begin
                    hasreq[l] = 1;
                    if (grant[l] < 0)
                        grant[l] = s;
                end
            end
            if (flush || mq[l].size() >= DEPTH)
                grant[l] = -1;
            if (grant[l] >= 0)
                exp_ready[grant[l]] = 1'b1;
        end
        last_ready = src_ready;
        check("src_ready", 64'(src_ready), 64'(exp_ready));
        for (int l = 0; l < NF; l++) begin
            exp_head = '0;
            if (mq[l].size() != 0)
                exp_head = mq[l][0];
            check($sformatf("fu_valid[%0d]", l), 64'(fu_valid[l]), 64'(mq[l].size() != 0));
            check($sformatf("fu_uop[%0d]", l), 64'(fu_uop[l]), 64'(exp_head));
            check($sformatf("perf_stall[%0d]", l), 64'(perf_stall[l]), 64'(mperf[l]));
        end
        for (int l = 0; l < NF; l++) begin
`ifdef Z480_DISPATCH_PERF_EN
            if (hasreq[l] && !flush && mq[l].size() == DEPTH && mperf[l] < 64'hFFFF_FFFF)
                mperf[l]++;
`endif
            if (flush) begin
                mq[l].delete();
            end else begin
                if (mq[l].size() != 0 && fu_ready[l])
                    void'(mq[l].pop_front());
                if (grant[l] >= 0) begin
                    mq[l].push_back(src_uop[grant[l]]);
                    mrr[l] = (grant[l] + 1) % NS;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        offer(0, 1'b0, 3'd0, 8'h00);
        offer(1, 1'b0, 3'd0, 8'h00);
    endtask

    int acc;
    logic [7:0] t;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        fu_ready = '0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_src_ready", 64'(src_ready), 64'(0));
        check("rst_fu_valid", 64'(fu_valid), 64'(0));
        for (int l = 0; l < NF; l++) begin
            check("rst_fu_uop", 64'(fu_uop[l]), 64'(0));
            check("rst_perf", 64'(perf_stall[l]), 64'(0));
        end
        rst_n = 1'b1;

        // Single BR uop
        offer(0, 1'b1, 3'd1, 8'h11);
        step();
        check("single_ready", 64'(last_ready), 64'(2'b01));
        idle();
        check("single_valid", 64'(fu_valid), 64'(5'b00010));
        check("single_tag", 64'(fu_uop[1].tag), 64'(8'h11));
        step();
        fu_ready = '1;
        step();

        // Parallel INT and MEM
        fu_ready = '0;
        offer(0, 1'b1, 3'd0, 8'h01);
        offer(1, 1'b1, 3'd4, 8'h02);
        step();
        check("par_ready", 64'(last_ready), 64'(2'b11));
        idle();
        check("par_valid", 64'(fu_valid), 64'(5'b10001));
        check("par_tag0", 64'(fu_uop[0].tag), 64'(8'h01));
        check("par_tag4", 64'(fu_uop[4].tag), 64'(8'h02));
        fu_ready = '1;
        step();

        // Round-robin on MD
        fu_ready = 5'b00100;
        for (int c = 0; c < 6; c++) begin
            offer(0, 1'b1, 3'd2, 8'(8'h20 + c));
            offer(1, 1'b1, 3'd2, 8'(8'h30 + c));
            step();
            check("rr_grant", 64'(last_ready), 64'((c % 2 == 0) ? 2'b01 : 2'b10));
        end
        idle();
        repeat (2) step();

        // Backpressure on VEC
        fu_ready = '0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            offer(0, 1'b1, 3'd3, 8'(8'h40 + c));
            step();
            acc += int'(last_ready[0]);
        end
        check("bp_accepts", 64'(acc), 64'(DEPTH));
`ifdef Z480_DISPATCH_PERF_EN
        check("bp_perf", 64'(perf_stall[3]), 64'(3));
`endif
        idle();
        fu_ready[3] = 1'b1;
        repeat (3) step();

        // Flush with INT and MEM holding two uops each
        fu_ready = '0;
        for (int c = 0; c < 2; c++) begin
            offer(0, 1'b1, 3'd0, 8'(8'h50 + c));
            offer(1, 1'b1, 3'd4, 8'(8'h60 + c));
            step();
        end
        offer(1, 1'b0, 3'd0, 8'h00);
        offer(0, 1'b1, 3'd0, 8'h5f);
        flush = 1'b1;
        step();
        check("flush_ready", 64'(last_ready), 64'(0));
        flush = 1'b0;
        check("flush_empty", 64'(fu_valid), 64'(0));
        step();
        check("flush_after_ready", 64'(last_ready), 64'(2'b01));
        idle();
        fu_ready = '1;
        step();

        // Randomized traffic, including unlisted fu encodings and occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                t = 8'($urandom);
                offer(i, 1'($urandom), 3'($urandom_range(0, 7)), t);
            end
            fu_ready = 5'($urandom);
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with non-empty lanes
        fu_ready = '0;
        for (int c = 0; c < 2; c++) begin
            offer(0, 1'b1, 3'd2, 8'(8'h70 + c));
            offer(1, 1'b1, 3'd3, 8'(8'h80 + c));
            step();
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_fu_valid", 64'(fu_valid), 64'(0));
        for (int l = 0; l < NF; l++)
            check("arst_perf", 64'(perf_stall[l]), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NS; i++)
                offer(i, 1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
            fu_ready = 5'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z480_fu_dispatch.md
# z480_fu_dispatch

Parametrised dispatch stage for the Z480 P7 core: accepts tagged uops from `NUM_SRC` ready-queue sources and routes each to one of five functional-unit (FU) lanes by its `fu` field. Each lane arbitrates round-robin among its sources and buffers uops in a per-lane FIFO that registers the FU-side output. The block sits between the RS/LSQ issue queues and the INT/BR/MD/VEC/MEM execution units, and supersedes the single-select combinational scheduler.

## Interface
- `NUM_SRC`, 2: number of issue sources. Must be ≥1. Source 0 is RS and source 1 is LSQ in the default build.
- `OUT_DEPTH`, 2: per-lane FIFO depth. Must be ≥1.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  pipeline flush. Synchronous in effect.
- `src_valid`  in  [NUM_SRC]  source offers a uop.
- `src_uop`  in  [NUM_SRC] x `z480_uop_tagged_t`  offered uops.
- `src_ready`  out  [NUM_SRC]  source uop accepted this cycle.
- `fu_valid`  out  [Z480_NUM_FU]  lane head valid.
- `fu_uop`  out  [Z480_NUM_FU] x `z480_uop_tagged_t`  lane head uop.
- `fu_ready`  in  [Z480_NUM_FU]  FU consumes the lane head.
- `perf_stall`  out  [Z480_NUM_FU] x 32  per-lane stall counters (see Configuration).

## Operation
- Lane index is taken from `src_uop[i].uop.uop.fu`:
  - INT=0, BR=1, MD=2, VEC=3, MEM=4.
  - Any `fu` encoding not listed maps to INT, matching the existing default routing.
- Lane L has requesters = {i : src_valid[i] && lane(i)==L}.
- Lane L grants one requester when `!flush` and `count[L] < OUT_DEPTH`.
  - The grant goes to the first requester at or after `rr_ptr[L]`, scanning upward modulo NUM_SRC.
- `src_ready[i]` = 1 iff source i is granted by its lane. It is combinational from src_valid, src_uop, the lane counts, rr_ptr and flush. It does not depend on `fu_ready`.
- Throughput:
  - Up to one push per lane per cycle.
  - Sources targeting different lanes are accepted in the same cycle.
  - Sources targeting the same lane are serialised.
- On a grant to source g, `rr_ptr[L]` ← (g+1) mod NUM_SRC. Otherwise `rr_ptr[L]` holds.
- Lane FIFO:
  - Pop when `fu_valid[L] && fu_ready[L]`.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - `fu_valid[L]` = (count[L] != 0).
  - `fu_uop[L]` = FIFO head, driven from registers.
  - `fu_uop[L]` = '0 when the lane is empty.
- Flush:
  - With `flush`=1, all `src_ready` are 0 that cycle.
  - All lane counts and read/write pointers clear at the next edge; pops that cycle are discarded.
  - `rr_ptr` is retained.
- Width rules:
  - count is `$clog2(OUT_DEPTH+1)` bits.
  - FIFO pointers are `$clog2(OUT_DEPTH)` bits (minimum 1) and wrap at OUT_DEPTH-1 → 0, including for non-power-of-2 depths.
  - `rr_ptr` is `$clog2(NUM_SRC)` bits (minimum 1).
- Reset values: all counts and pointers 0, `rr_ptr` 0, `fu_valid` 0, `fu_uop` '0, `src_ready` 0, `perf_stall` 0.
- Reset asserted mid-operation discards all buffered uops immediately (asynchronously).

## Timing
- Latency: a uop accepted at edge N appears on `fu_valid` after edge N, i.e. in cycle N+1. There is no combinational source→FU path.
- Sustained rate is one uop per lane per cycle when OUT_DEPTH ≥ 2.
- With OUT_DEPTH = 1, the lane alternates push and pop, giving half rate. This is legal but not the intended configuration.
- Handshake:
  - The FU may not rely on `fu_uop` after the consuming edge.
  - Sources must hold `src_uop` stable while `src_valid` is high and `src_ready` is low. The block does not check this.
- Empty lane plus push: `fu_valid` rises the next cycle.
- Full lane with pop in the same cycle: no push that cycle, because ready does not look at `fu_ready`. The push happens the following cycle.

## Configuration
- Macro: `Z480_DISPATCH_PERF_EN`.
- Defined:
  - `perf_stall[L]` increments every cycle that lane L has ≥1 requester, `!flush`, and `count[L]==OUT_DEPTH`.
  - It saturates at 32'hFFFF_FFFF.
  - It is not cleared by flush; only reset clears it.
- Undefined: the counters are not built and `perf_stall` is tied to 0. The port list is identical in both builds.

## Structure
- `z480_pkg` additions:
  - `Z480_NUM_FU` = 5.
  - `z480_fu_lane_e` (INT, BR, MD, VEC, MEM lane indices).
  - Function `z480_fu_to_lane()`, mapping the `fu` field to a lane with default INT.
- Sub-module `z480_fu_lane_fifo`:
  - Parameters: DEPTH.
  - Ports: push, push_uop, pop, clr, count, head_valid, head_uop.
  - Instantiated Z480_NUM_FU times by generate.
- The round-robin grant logic is a function inside `z480_fu_dispatch`.

## Test plan
- Single uop:
  - Stimulus: reset released; src0 offers a BR uop (tag 0x11) for one cycle; `fu_ready` all 0.
  - Required: `src_ready[0]`=1 in that cycle; `fu_valid[1]`=1 with tag 0x11 from the next cycle; all other lanes 0.
- Parallel lanes:
  - Stimulus: src0 offers INT (tag 0x01) and src1 offers MEM (tag 0x02) in the same cycle.
  - Required: both `src_ready`=1; one cycle later `fu_valid[0]` and `fu_valid[4]` are both 1 with matching tags.
- Round-robin:
  - Stimulus: both sources continuously offer MD uops; `fu_ready[2]`=1.
  - Required: grants alternate src0, src1, src0, … starting from src0; one pop per cycle after the first.
- Backpressure:
  - Stimulus: `fu_ready[3]`=0; src0 streams VEC uops.
  - Required: exactly OUT_DEPTH (2) accepts, then `src_ready[0]`=0. With the macro defined, `perf_stall[3]` increments by 1 per cycle from then on.
  - Then raise `fu_ready[3]`: uops drain in FIFO order.
- Flush:
  - Stimulus: lanes INT and MEM hold 2 uops each; assert `flush` for one cycle while src0 is valid.
  - Required: `src_ready`=0 that cycle; all `fu_valid`=0 the next cycle; the src0 uop is accepted in the cycle after flush deasserts.
- Async reset:
  - Stimulus: assert `rst_n`=0 between clock edges while lanes are non-empty.
  - Required: `fu_valid` all 0 immediately, before the next edge; `perf_stall` reads 0.
